operand2_sequencer: RTL and testbench

- Decode/issue stage controller in front of the source operand2 handler.
- Accepts SPARC instruction words from fetch and decodes op/op2/op3/i to produce the 4-bit operand select code (IS).
- Forms the 22-bit immediate field and registers the rs2 value, presenting a registered, handshaked operand bundle to execute.
- Splits LDD/STD into two issue beats so execute can form the second word address.

---
 rtl/operand2_pkg.sv | 45 ++++
 rtl/operand2_decode.sv | 70 +++++++
 rtl/operand2_sequencer.sv | 119 +++++++++++
 tb/tb_operand2_sequencer.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/operand2_pkg.sv
// ============================================================================
// operand2_pkg : IS codes, SPARC opcode fields and sequencer state encoding
// Revision 1.0
// ============================================================================
`default_nettype none

package operand2_pkg;

  localparam logic [3:0] IS_SETHI  = 4'b0000;
  localparam logic [3:0] IS_DISP22 = 4'b0100;
  localparam logic [3:0] IS_REG    = 4'b1000;
  localparam logic [3:0] IS_SIMM13 = 4'b1001;
  localparam logic [3:0] IS_SHREG  = 4'b1010;
  localparam logic [3:0] IS_SHIMM  = 4'b1011;
  localparam logic [3:0] IS_LSREG  = 4'b1100;
  localparam logic [3:0] IS_LSIMM  = 4'b1101;

  localparam logic [1:0] OP_FMT2  = 2'b00;
  localparam logic [1:0] OP_CALL  = 2'b01;
  localparam logic [1:0] OP_ARITH = 2'b10;
  localparam logic [1:0] OP_MEM   = 2'b11;

  localparam logic [2:0] OP2_SETHI = 3'b100;
  localparam logic [2:0] OP2_BICC  = 3'b010;
  localparam logic [2:0] OP2_FBFCC = 3'b110;

  localparam logic [5:0] OP3_SLL = 6'b100101;
  localparam logic [5:0] OP3_SRL = 6'b100110;
  localparam logic [5:0] OP3_SRA = 6'b100111;
  localparam logic [5:0] OP3_LDD = 6'b000011;
  localparam logic [5:0] OP3_STD = 6'b000111;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_DW2   = 2'd2
  } seq_state_t;

  function automatic logic [21:0] sext13(input logic [12:0] v);
    return {{9{v[12]}}, v};
  endfunction

endpackage

`default_nettype wire

// File: rtl/operand2_decode.sv
// ============================================================================
// operand2_decode : combinational SPARC instruction to operand2 select decode
// Revision 1.0
// ============================================================================
`default_nettype none

module operand2_decode
  import operand2_pkg::*;
#(
  parameter int DW_SPLIT = 1
) (
  input  logic [31:0] inst,
  output logic [3:0]  is_sel,
  output logic [21:0] imm22,
  output logic        no_op2,
  output logic        is_dw
);

  logic [1:0] op;
  logic [2:0] op2;
  logic [5:0] op3;
  logic       imm_bit;
  logic       unused_bits;

  assign op          = inst[31:30];
  assign op2         = inst[24:22];
  assign op3         = inst[24:19];
  assign imm_bit     = inst[13];
  assign unused_bits = ^inst[29:25];

  always_comb begin
    is_sel = IS_REG;
    imm22  = '0;
    no_op2 = 1'b1;
    is_dw  = 1'b0;
    case (op)
      OP_FMT2: begin
        if (op2 == OP2_SETHI) begin
          is_sel = IS_SETHI;
          imm22  = inst[21:0];
          no_op2 = 1'b0;
        end else if (op2 == OP2_BICC || op2 == OP2_FBFCC) begin
          is_sel = IS_DISP22;
          imm22  = inst[21:0];
          no_op2 = 1'b0;
        end
      end
      OP_CALL: begin
        no_op2 = 1'b1;
      end
      OP_ARITH: begin
        no_op2 = 1'b0;
        imm22  = sext13(inst[12:0]);
        if (op3 inside {OP3_SLL, OP3_SRL, OP3_SRA})
          is_sel = imm_bit ? IS_SHIMM : IS_SHREG;
        else
          is_sel = imm_bit ? IS_SIMM13 : IS_REG;
      end
      OP_MEM: begin
        no_op2 = 1'b0;
        imm22  = sext13(inst[12:0]);
        is_sel = imm_bit ? IS_LSIMM : IS_LSREG;
        is_dw  = (DW_SPLIT != 0) && (op3 == OP3_LDD || op3 == OP3_STD);
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/operand2_sequencer.sv
// ============================================================================
// operand2_sequencer : decode/issue controller presenting a registered operand2
// bundle to execute. Optional counters via OPSEQ_PERF_CNT_EN. Revision 1.0
// ============================================================================
`default_nettype none

module operand2_sequencer
  import operand2_pkg::*;
#(
  parameter int DW_SPLIT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_valid,
  output logic        inst_ready,
  input  logic [31:0] inst,
  input  logic [31:0] rs2_data,
  input  logic        flush,
  output logic        ex_valid,
  input  logic        ex_ready,
  output logic [3:0]  is_sel,
  output logic [21:0] imm22,
  output logic [31:0] r_out,
  output logic        no_op2,
`ifdef OPSEQ_PERF_CNT_EN
  output logic [31:0] issue_cnt,
  output logic [31:0] stall_cnt,
`endif
  output logic        dw_second
);

  seq_state_t state, state_nxt;

  logic [3:0]  dec_is_sel;
  logic [21:0] dec_imm22;
  logic        dec_no_op2;
  logic        dec_is_dw;
  logic        dw_held;
  logic        load;

  operand2_decode #(
    .DW_SPLIT (DW_SPLIT)
  ) u_decode (
    .inst   (inst),
    .is_sel (dec_is_sel),
    .imm22  (dec_imm22),
    .no_op2 (dec_no_op2),
    .is_dw  (dec_is_dw)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_EMPTY;
    else       state <= state_nxt;
  end

  // flush bypasses the case entirely, so inst_ready stays 0 on that cycle
  always_comb begin
    state_nxt  = state;
    inst_ready = 1'b0;
    ex_valid   = (state != ST_EMPTY);
    dw_second  = (state == ST_DW2);
    if (flush) begin
      state_nxt = ST_EMPTY;
    end else begin
      case (state)
        ST_EMPTY: begin
          inst_ready = 1'b1;
          if (inst_valid) state_nxt = ST_FULL;
        end
        ST_FULL: begin
          inst_ready = ex_ready && !dw_held;
          if (ex_ready) begin
            if (dw_held)         state_nxt = ST_DW2;
            else if (inst_valid) state_nxt = ST_FULL;
            else                 state_nxt = ST_EMPTY;
          end
        end
        ST_DW2: begin
          inst_ready = ex_ready;
          if (ex_ready) state_nxt = inst_valid ? ST_FULL : ST_EMPTY;
        end
        default: state_nxt = ST_EMPTY;
      endcase
    end
  end

  assign load = inst_ready && inst_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      is_sel  <= '0;
      imm22   <= '0;
      r_out   <= '0;
      no_op2  <= 1'b0;
      dw_held <= 1'b0;
    end else if (load) begin
      is_sel  <= dec_is_sel;
      imm22   <= dec_imm22;
      r_out   <= dec_no_op2 ? 32'd0 : rs2_data;
      no_op2  <= dec_no_op2;
      dw_held <= dec_is_dw;
    end
  end

`ifdef OPSEQ_PERF_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      issue_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (ex_valid && ex_ready)  issue_cnt <= issue_cnt + 32'd1;
      if (ex_valid && !ex_ready) stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_operand2_sequencer.sv
// ============================================================================
// tb_operand2_sequencer : vector table, corner sequences and random model check
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_operand2_sequencer;

  logic        clk = 1'b0;
  logic        reset, inst_valid, inst_ready, flush, ex_valid, ex_ready, no_op2, dw_second;
  logic [31:0] inst, rs2_data, r_out;
  logic [3:0]  is_sel;
  logic [21:0] imm22;
`ifdef OPSEQ_PERF_CNT_EN
  logic [31:0] issue_cnt, stall_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  operand2_sequencer #(.DW_SPLIT(1)) dut (
    .clk        (clk),
    .reset      (reset),
    .inst_valid (inst_valid),
    .inst_ready (inst_ready),
    .inst       (inst),
    .rs2_data   (rs2_data),
    .flush      (flush),
    .ex_valid   (ex_valid),
    .ex_ready   (ex_ready),
    .is_sel     (is_sel),
    .imm22      (imm22),
    .r_out      (r_out),
    .no_op2     (no_op2),
`ifdef OPSEQ_PERF_CNT_EN
    .issue_cnt  (issue_cnt),
    .stall_cnt  (stall_cnt),
`endif
    .dw_second  (dw_second)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] rs2;
    logic [3:0]  is_sel;
    logic [21:0] imm22;
    logic [31:0] r;
    logic        no_op2;
  } vec_t;

  typedef struct {
    logic [3:0]  is_sel;
    logic [21:0] imm22;
    logic [31:0] r;
    logic        no_op2;
    logic        dw;
  } bundle_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_bundle(input string tag, input logic [3:0] e_is, input logic [21:0] e_imm,
                            input logic [31:0] e_r, input logic e_no, input logic e_dw2);
    chk({tag, "_ex_valid"}, ex_valid, 1);
    chk({tag, "_is_sel"}, is_sel, e_is);
    chk({tag, "_imm22"}, imm22, e_imm);
    chk({tag, "_r_out"}, r_out, e_r);
    chk({tag, "_no_op2"}, no_op2, e_no);
    chk({tag, "_dw_second"}, dw_second, e_dw2);
  endtask

  // Reference decode straight from the instruction-field rules
  function automatic bundle_t ref_decode(input logic [31:0] w, input logic [31:0] rs2);
    bundle_t b;
    logic [1:0]  op   = w[31:30];
    logic [2:0]  op2  = w[24:22];
    logic [5:0]  op3  = w[24:19];
    logic        i    = w[13];
    logic [21:0] simm = {{9{w[12]}}, w[12:0]};
    b = '{4'b1000, 22'd0, 32'd0, 1'b1, 1'b0};
    if (op == 2'b00 && op2 == 3'b100)
      b = '{4'b0000, w[21:0], rs2, 1'b0, 1'b0};
    else if (op == 2'b00 && (op2 == 3'b010 || op2 == 3'b110))
      b = '{4'b0100, w[21:0], rs2, 1'b0, 1'b0};
    else if (op == 2'b10) begin
      if (op3 == 6'h25 || op3 == 6'h26 || op3 == 6'h27)
        b = '{i ? 4'b1011 : 4'b1010, simm, rs2, 1'b0, 1'b0};
      else
        b = '{i ? 4'b1001 : 4'b1000, simm, rs2, 1'b0, 1'b0};
    end else if (op == 2'b11)
      b = '{i ? 4'b1101 : 4'b1100, simm, rs2, 1'b0, (op3 == 6'h03 || op3 == 6'h07)};
    return b;
  endfunction

  function automatic logic [31:0] rnd_inst();
    logic [31:0] w = $urandom;
    case ($urandom_range(0, 7))
      0: begin w[31:30] = 2'b11; w[24:19] = 6'b000011; end
      1: begin w[31:30] = 2'b11; w[24:19] = 6'b000111; end
      2: w[31:30] = 2'b10;
      3: w[31:30] = 2'b00;
      4: begin w[31:30] = 2'b10; w[24:19] = 6'b100101 + 6'($urandom_range(0, 2)); end
      default: ;
    endcase
    return w;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  vec_t    vecs[12];
  bundle_t cur;
  int      bl;
  logic    exp_rdy, mv;
  logic [31:0] m_issue, m_stall, s0;

  initial begin
    vecs[0]  = '{32'h03000040, 32'hDEADBEEF, 4'b0000, 22'h000040, 32'hDEADBEEF, 1'b0};
    vecs[1]  = '{32'h82007FFF, 32'h01234567, 4'b1001, 22'h3FFFFF, 32'h01234567, 1'b0};
    vecs[2]  = '{32'h82006005, 32'h89ABCDEF, 4'b1001, 22'h000005, 32'h89ABCDEF, 1'b0};
    vecs[3]  = '{32'h82000002, 32'h55AA55AA, 4'b1000, 22'h000002, 32'h55AA55AA, 1'b0};
    vecs[4]  = '{32'h81282003, 32'h00000011, 4'b1011, 22'h000003, 32'h00000011, 1'b0};
    vecs[5]  = '{32'h81380001, 32'h00000022, 4'b1010, 22'h000001, 32'h00000022, 1'b0};
    vecs[6]  = '{32'hC0002010, 32'h00000033, 4'b1101, 22'h000010, 32'h00000033, 1'b0};
    vecs[7]  = '{32'hC0200005, 32'h00000044, 4'b1100, 22'h000005, 32'h00000044, 1'b0};
    vecs[8]  = '{32'h00812345, 32'h00000055, 4'b0100, 22'h012345, 32'h00000055, 1'b0};
    vecs[9]  = '{32'h01BFFFFF, 32'h00000066, 4'b0100, 22'h3FFFFF, 32'h00000066, 1'b0};
    vecs[10] = '{32'h40001234, 32'hFFFFFFFF, 4'b1000, 22'h000000, 32'h00000000, 1'b1};
    vecs[11] = '{32'hC0203000, 32'h00000077, 4'b1101, 22'h3FF000, 32'h00000077, 1'b0};

    reset = 1'b1; inst_valid = 1'b0; inst = '0; rs2_data = '0; flush = 1'b0; ex_ready = 1'b0;
    tick(); tick();
    chk("rst_ex_valid", ex_valid, 0);
    chk("rst_is_sel", is_sel, 0);
    chk("rst_imm22", imm22, 0);
    chk("rst_r_out", r_out, 0);
    chk("rst_no_op2", no_op2, 0);
    chk("rst_dw_second", dw_second, 0);
    reset = 1'b0;
    #1 chk("empty_inst_ready", inst_ready, 1);

    for (int k = 0; k < 12; k++) begin
      inst_valid = 1'b1; inst = vecs[k].inst; rs2_data = vecs[k].rs2; ex_ready = 1'b1;
      #1 chk($sformatf("tbl%0d_ready", k), inst_ready, 1);
      tick();
      inst_valid = 1'b0; inst = $urandom; rs2_data = $urandom;
      chk_bundle($sformatf("tbl%0d", k), vecs[k].is_sel, vecs[k].imm22, vecs[k].r, vecs[k].no_op2, 1'b0);
      tick();
      chk($sformatf("tbl%0d_drained", k), ex_valid, 0);
    end

    // LDD issued as two beats, next instruction taken on the second beat
    inst_valid = 1'b1; inst = 32'hC0182008; rs2_data = 32'h11112222; ex_ready = 1'b1;
    tick();
    inst = 32'h03000040; rs2_data = 32'hAAAA5555;
    #1;
    chk_bundle("ldd_b1", 4'b1101, 22'h000008, 32'h11112222, 1'b0, 1'b0);
    chk("ldd_b1_inst_ready", inst_ready, 0);
    tick();
    chk_bundle("ldd_b2", 4'b1101, 22'h000008, 32'h11112222, 1'b0, 1'b1);
    chk("ldd_b2_inst_ready", inst_ready, 1);
    tick();
    chk_bundle("ldd_next", 4'b0000, 22'h000040, 32'hAAAA5555, 1'b0, 1'b0);

    // Three stall cycles hold the bundle
    ex_ready = 1'b0; inst = 32'h82007FFF; rs2_data = 32'h0;
`ifdef OPSEQ_PERF_CNT_EN
    s0 = stall_cnt;
`endif
    for (int k = 0; k < 3; k++) begin
      #1 chk($sformatf("stall%0d_inst_ready", k), inst_ready, 0);
      tick();
      chk_bundle($sformatf("stall%0d", k), 4'b0000, 22'h000040, 32'hAAAA5555, 1'b0, 1'b0);
    end
`ifdef OPSEQ_PERF_CNT_EN
    chk("stall_cnt_delta", stall_cnt - s0, 3);
`endif
    inst_valid = 1'b0; ex_ready = 1'b1;
    tick();
    chk("stall_drained", ex_valid, 0);

    // Flush while in DW2 discards the second beat
    inst_valid = 1'b1; inst = 32'hC0382000; rs2_data = 32'h0000BEEF;
    tick();
    inst_valid = 1'b0;
    tick();
    chk("fl_dw2_dw_second", dw_second, 1);
    flush = 1'b1; ex_ready = 1'b0; inst_valid = 1'b1; inst = 32'h03000040;
    #1 chk("fl_inst_ready", inst_ready, 0);
    tick();
    flush = 1'b0; inst_valid = 1'b0;
    chk("fl_ex_valid", ex_valid, 0);
    chk("fl_dw_second", dw_second, 0);
    tick();
    chk("fl_after_ex_valid", ex_valid, 0);
    chk("fl_after_inst_ready", inst_ready, 1);

    // Asynchronous reset in the middle of a FULL cycle
    inst_valid = 1'b1; inst = 32'h82007FFF; rs2_data = 32'h12345678; ex_ready = 1'b0;
    tick();
    inst_valid = 1'b0;
    chk("ar_ex_valid_before", ex_valid, 1);
    #2 reset = 1'b1;
    #1;
    chk("ar_ex_valid", ex_valid, 0);
    chk("ar_is_sel", is_sel, 0);
    chk("ar_imm22", imm22, 0);
    chk("ar_r_out", r_out, 0);
    chk("ar_no_op2", no_op2, 0);
    chk("ar_dw_second", dw_second, 0);
`ifdef OPSEQ_PERF_CNT_EN
    chk("ar_issue_cnt", issue_cnt, 0);
    chk("ar_stall_cnt", stall_cnt, 0);
`endif
    tick();
    reset = 1'b0;

    // Random traffic against the reference model
    bl = 0; m_issue = '0; m_stall = '0; cur = '{4'b0, 22'd0, 32'd0, 1'b0, 1'b0};
    for (int n = 0; n < 600; n++) begin
      flush      = ($urandom_range(0, 15) == 0);
      inst_valid = ($urandom_range(0, 3) != 0);
      ex_ready   = ($urandom_range(0, 3) != 0);
      inst       = rnd_inst();
      rs2_data   = $urandom;
      #1;
      exp_rdy = !flush && (bl == 0 || (ex_ready && bl == 1));
      chk("rnd_inst_ready", inst_ready, exp_rdy);
      mv = (bl > 0);
      if (mv && ex_ready)  m_issue++;
      if (mv && !ex_ready) m_stall++;
      if (flush) bl = 0;
      else begin
        if (mv && ex_ready) bl--;
        if (exp_rdy && inst_valid) begin
          cur = ref_decode(inst, rs2_data);
          bl  = cur.dw ? 2 : 1;
        end
      end
      tick();
      chk("rnd_ex_valid", ex_valid, bl > 0);
      chk("rnd_dw_second", dw_second, (bl == 1) && cur.dw);
      if (bl > 0) begin
        chk("rnd_is_sel", is_sel, cur.is_sel);
        chk("rnd_imm22", imm22, cur.imm22);
        chk("rnd_r_out", r_out, cur.r);
        chk("rnd_no_op2", no_op2, cur.no_op2);
      end
`ifdef OPSEQ_PERF_CNT_EN
      chk("rnd_issue_cnt", issue_cnt, m_issue);
      chk("rnd_stall_cnt", stall_cnt, m_stall);
`endif
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
